// File: rtl/gate_reduce_unit_if.sv
// Stream bundle for gate_reduce_unit: operand beats in, one folded result word out.
// The slave modport is the reducer; the master modport is the operand source plus the result consumer.
interface gate_reduce_unit_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic [2:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_trunc;

  modport slave (
    input  mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_trunc
  );

  modport master (
    output mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_trunc
  );
endinterface

// File: rtl/gate_reduce_unit.sv
// WIDTH-bit multi-input logic gate: folds a serial frame of up to MAX_INPUTS operands
// with AND/OR/XOR and emits one registered result per frame, optionally inverted.
module gate_reduce_unit #(
  parameter int WIDTH      = 8,
  parameter int MAX_INPUTS = 8,
  parameter int CW         = $clog2(MAX_INPUTS + 1)
) (
  input logic               clk,
  input logic               rst,
  gate_reduce_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
  typedef enum logic [1:0] {OP_AND = 2'd0, OP_OR = 2'd1, OP_XOR = 2'd2} op_t;

  localparam logic [CW-1:0] CAP = CW'(MAX_INPUTS);

  state_t           state, state_n;
  op_t              op, op_n;
  logic             inv, inv_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             out_valid, out_valid_n;
  logic [WIDTH-1:0] out_data, out_data_n;
  logic [CW-1:0]    out_count, out_count_n;
  logic             out_trunc, out_trunc_n;
  logic             ready;
  logic             accept;
  logic             close;

  function automatic logic [WIDTH-1:0] fold(input op_t o, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (o)
      OP_AND:  fold = a & b;
      OP_OR:   fold = a | b;
      OP_XOR:  fold = a ^ b;
      default: fold = a & b;
    endcase
  endfunction

  // ready depends only on state and reset, so there is no combinational in->out path
  assign ready  = (state != HOLD) && !rst;
  assign accept = bus.in_valid && ready;

  // Next-state, accumulator fold and frame-close result capture
  always_comb begin
    state_n     = state;
    op_n        = op;
    inv_n       = inv;
    acc_n       = acc;
    cnt_n       = cnt;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_count_n = out_count;
    out_trunc_n = out_trunc;
    close       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_n = bus.in_data;
          cnt_n = CW'(1);
          case (bus.mode)
            3'd0:    begin op_n = OP_AND; inv_n = 1'b0; end
            3'd1:    begin op_n = OP_AND; inv_n = 1'b1; end
            3'd2:    begin op_n = OP_OR;  inv_n = 1'b0; end
            3'd3:    begin op_n = OP_OR;  inv_n = 1'b1; end
            3'd4:    begin op_n = OP_XOR; inv_n = 1'b0; end
            3'd5:    begin op_n = OP_XOR; inv_n = 1'b1; end
            default: begin op_n = OP_AND; inv_n = 1'b1; end
          endcase
          if (bus.in_last || (MAX_INPUTS == 1)) begin
            close = 1'b1;
          end else begin
            state_n = ACCUM;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_n = fold(op, acc, bus.in_data);
          cnt_n = cnt + CW'(1);
          close = bus.in_last || (cnt_n == CAP);
        end else begin
          state_n = ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end else begin
          state_n = HOLD;
        end
      end
      default: state_n = IDLE;
    endcase
    // trunc only when the cap closed the frame and in_last was absent on that beat
    if (close) begin
      state_n     = HOLD;
      out_valid_n = 1'b1;
      out_data_n  = acc_n ^ {WIDTH{inv_n}};
      out_count_n = cnt_n;
      out_trunc_n = !bus.in_last;
    end else begin
      out_trunc_n = out_trunc_n;
    end
  end

  // State, accumulator and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= OP_AND;
      inv       <= 1'b0;
      acc       <= {WIDTH{1'b0}};
      cnt       <= {CW{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_count <= {CW{1'b0}};
      out_trunc <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      inv       <= inv_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_count <= out_count_n;
      out_trunc <= out_trunc_n;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_count = out_count;
  assign bus.out_trunc = out_trunc;
endmodule

// File: tb/tb_gate_reduce_unit.sv
// Self-checking bench for gate_reduce_unit (WIDTH=8, MAX_INPUTS=4): directed cases plus
// randomized frames compared against a frame-level reference model.
module tb_gate_reduce_unit;
  localparam int WIDTH = 8;
  localparam int MAXI  = 4;
  localparam int CW    = $clog2(MAXI + 1);

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  gate_reduce_unit_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  gate_reduce_unit #(.WIDTH(WIDTH), .MAX_INPUTS(MAXI)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] ops[$];
  logic [2:0] mmode;
  int         mcnt;
  logic       pend;
  int         exp_d, exp_c, exp_t;
  int         hs_q[$];
  logic       rnd_rdy;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int word(input int d, input int c, input int t);
    return d + c * 256 + t * 4096;
  endfunction

  // Gate of all operands in the frame, straight from the mode table
  function automatic logic [7:0] gate_of(input logic [2:0] m);
    logic [7:0] r;
    if (m == 3'd2 || m == 3'd3) begin
      r = 8'h00;
      foreach (ops[i]) r = r | ops[i];
    end else if (m == 3'd4 || m == 3'd5) begin
      r = 8'h00;
      foreach (ops[i]) r = r ^ ops[i];
    end else begin
      r = 8'hFF;
      foreach (ops[i]) r = r & ops[i];
    end
    if (m == 3'd1 || m == 3'd3 || m == 3'd5 || m == 3'd6 || m == 3'd7) r = ~r;
    return r;
  endfunction

  task automatic model_beat(input logic [7:0] d, input logic l, input logic [2:0] m);
    if (mcnt == 0) mmode = m;
    ops.push_back(d);
    mcnt++;
    if (l || mcnt == MAXI) begin
      exp_d = int'(gate_of(mmode));
      exp_c = mcnt;
      exp_t = l ? 0 : 1;
      pend  = 1'b1;
      ops.delete();
      mcnt = 0;
    end
  endtask

  task automatic model_reset();
    ops.delete();
    mcnt = 0;
    pend = 1'b0;
  endtask

  // One clock: check outputs against model, drive inputs, predict the coming edge
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic [2:0] m,
                      input logic r, output logic acc);
    @(negedge clk);
    check("out_valid", int'(bus.out_valid), int'(pend));
    check("in_ready", int'(bus.in_ready), int'(!pend));
    if (pend) begin
      check("out_data", int'(bus.out_data), exp_d);
      check("out_count", int'(bus.out_count), exp_c);
      check("out_trunc", int'(bus.out_trunc), exp_t);
    end
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.mode      = m;
    bus.out_ready = r;
    acc = v && bus.in_ready;
    if (pend && r) begin
      hs_q.push_back(word(int'(bus.out_data), int'(bus.out_count), int'(bus.out_trunc)));
      pend = 1'b0;
    end
    if (acc) model_beat(d, l, m);
    @(posedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [2:0] m);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 64) begin
      step(1'b1, d, l, m, rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1, a);
      n++;
    end
    if (!a) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    logic a;
    int   n;
    n = 0;
    while (pend && n < 64) begin
      step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, a);
      n++;
    end
    if (pend) check("drain_timeout", 0, 1);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, a);
  endtask

  task automatic check_last(input string tag, input int exp);
    if (hs_q.size() == 0) check(tag, -1, exp);
    else check(tag, hs_q[$], exp);
  endtask

  logic [7:0] mode_tab[8];
  logic       a;

  initial begin
    checks   = 0;
    failures = 0;
    rnd_rdy  = 1'b0;
    model_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.mode      = 3'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_count", int'(bus.out_count), 0);
    check("rst_out_trunc", int'(bus.out_trunc), 0);
    rst = 1'b0;

    // NAND two-input truth table
    hs_q.delete();
    send(8'hF0, 1'b0, 3'd1); send(8'hCC, 1'b1, 3'd1); drain();
    check_last("nand_f0_cc", word(8'h3F, 2, 0));
    send(8'hFF, 1'b0, 3'd1); send(8'hFF, 1'b1, 3'd1); drain();
    check_last("nand_ff_ff", word(8'h00, 2, 0));
    send(8'h00, 1'b0, 3'd1); send(8'h00, 1'b1, 3'd1); drain();
    check_last("nand_00_00", word(8'hFF, 2, 0));

    // every mode over {A5,0F,3C}
    mode_tab = '{8'h04, 8'hFB, 8'hBF, 8'h40, 8'h96, 8'h69, 8'hFB, 8'hFB};
    for (int m = 0; m < 8; m++) begin
      send(8'hA5, 1'b0, 3'(m)); send(8'h0F, 1'b0, 3'(m)); send(8'h3C, 1'b1, 3'(m)); drain();
      check_last($sformatf("mode%0d", m), word(int'(mode_tab[m]), 3, 0));
    end

    // cap closes the first frame, the rest forms a second
    hs_q.delete();
    for (int i = 0; i < 6; i++) send(8'(1 << i), (i == 5), 3'd2);
    drain();
    if (hs_q.size() != 2) check("cap_frames", hs_q.size(), 2);
    else begin
      check("cap_first", hs_q[0], word(8'h0F, 4, 1));
      check("cap_second", hs_q[1], word(8'h30, 2, 0));
    end

    // cap and in_last on the same beat
    for (int i = 0; i < 4; i++) send(8'(1 << i), (i == 3), 3'd2);
    drain();
    check_last("cap_with_last", word(8'h0F, 4, 0));

    // backpressure in HOLD
    send(8'h3C, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h77, 1'b1, 3'd2, 1'b0, a);
      check("bp_no_accept", int'(a), 0);
    end
    step(1'b1, 8'h77, 1'b1, 3'd2, 1'b1, a);
    check("bp_hs_no_accept", int'(a), 0);
    step(1'b1, 8'h77, 1'b1, 3'd2, 1'b1, a);
    check("bp_resume", int'(a), 1);
    drain();
    check_last("bp_next_frame", word(8'h77, 1, 0));

    // single operand and mid-frame mode change
    send(8'h5A, 1'b1, 3'd3); drain();
    check_last("single_nor", word(8'hA5, 1, 0));
    send(8'hFF, 1'b0, 3'd0); send(8'h0F, 1'b1, 3'd4); drain();
    check_last("mode_latch", word(8'h0F, 2, 0));

    // asynchronous reset mid-frame
    send(8'hAA, 1'b0, 3'd0); send(8'hF0, 1'b0, 3'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_out_data", int'(bus.out_data), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hs_q.delete();
    send(8'h01, 1'b0, 3'd2); send(8'h02, 1'b1, 3'd2); drain();
    if (hs_q.size() != 1) check("post_rst_frames", hs_q.size(), 1);
    else check("post_rst_or", hs_q[0], word(8'h03, 2, 0));

    // randomized frames with idle gaps and random consumer stalls
    rnd_rdy = 1'b1;
    for (int f = 0; f < 300; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0)
          step(1'b0, 8'h00, 1'b0, 3'd0, ($urandom_range(0, 3) != 0), a);
        send(8'($urandom), (b == len - 1), 3'($urandom_range(0, 7)));
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
